// File: rtl/lupa_cap_pkg.sv
// Shared types and constants for the LUPA300 capture gate: FSM states,
// default window size and status bit positions.
package lupa_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACTIVE,
    DROP
  } cap_state_e;

  localparam int H_ACTIVE_DEF     = 640;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int PIX_W            = 8;
  localparam int STAT_SHORT_LINE  = 0;
  localparam int STAT_SHORT_FRAME = 1;

endpackage

// File: rtl/lupa_frame_gate_packer.sv
// pixel_packer: pairs accepted 8-bit pixels into 16-bit words with a one-cycle
// write strobe; a flush with a held pixel writes {held, 8'h00}.
module pixel_packer
  import lupa_cap_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PIX_W-1:0]     pix_i,
  input  logic                 accept_i,
  input  logic                 flush_i,
  input  logic                 clear_i,
  output logic [2*PIX_W-1:0]   data_o,
  output logic                 wr_o,
  output logic                 pend_o
);

  logic [PIX_W-1:0]   hold_q, hold_d;
  logic               phase_q, phase_d;
  logic [2*PIX_W-1:0] word_q, word_d;
  logic               wr_q, wr_d;

  always_comb begin
    hold_d  = hold_q;
    phase_d = phase_q;
    word_d  = word_q;
    wr_d    = 1'b0;
    if (clear_i) begin
      phase_d = 1'b0;
    end else if (accept_i) begin
      if (!phase_q) begin
        hold_d  = pix_i;
        phase_d = 1'b1;
      end else begin
        word_d  = {hold_q, pix_i};
        wr_d    = 1'b1;
        phase_d = 1'b0;
      end
    end else if (flush_i && phase_q) begin
      word_d  = {hold_q, {PIX_W{1'b0}}};
      wr_d    = 1'b1;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= 1'b0;
      word_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
    end
  end

  // Held byte is pure data; phase_q decides whether it is meaningful.
  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
  end

  assign data_o = word_q;
  assign wr_o   = wr_q;
  assign pend_o = phase_q;

endmodule

// File: rtl/lupa_frame_gate.sv
// lupa_frame_gate: crops LUPA300 pixels to the active window and packs pairs
// for the SDRAM write port. Optional frame decimation under `FRAME_SKIP_EN`.
module lupa_frame_gate
  import lupa_cap_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int SKIP_LOG2 = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [7:0]  iDATA,
  input  logic        iLV,
  input  logic        iFV,
  output logic [15:0] oDATA,
  output logic        oWR,
  output logic        oSOF,
  output logic        oEOF,
  output logic [1:0]  oSTAT
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] H_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_MAX = YW'(V_ACTIVE);

  // Input registers track the pins even during reset so that IDLE sees the
  // true frame-valid level and cannot mistake a mid-frame reset for a rise.
  logic [7:0] data_q;
  logic       lv_q, fv_q, lv_prev_q, fv_prev_q;
  logic       lv_act;

  always_ff @(posedge CLK) begin
    data_q    <= iDATA;
    lv_q      <= iLV;
    fv_q      <= iFV;
    lv_prev_q <= lv_act;
    fv_prev_q <= fv_q;
  end

  // Line valid only counts inside a frame, so FV falling with LV high ends the line too.
  assign lv_act = lv_q & fv_q;

  logic fv_rise, fv_fall, line_end;
  assign fv_rise  = fv_q & ~fv_prev_q;
  assign fv_fall  = ~fv_q & fv_prev_q;
  assign line_end = lv_prev_q & ~lv_act;

  cap_state_e    state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q, y_next;
  logic          sof_q, eof_q, eof_pend_q;
  logic [1:0]    stat_q;
  logic          frame_sel;
  logic          in_active, accept, flush, clear, pend;

  assign in_active = (state_q == ACTIVE);
  assign accept    = in_active & lv_act & (x_q < H_MAX) & (y_q < V_MAX);
  assign flush     = in_active & line_end;
  assign clear     = (state_q == WAIT) & fv_rise & ENABLE & frame_sel;
  assign y_next    = (line_end && (y_q != V_MAX)) ? y_q + 1'b1 : y_q;

`ifdef FRAME_SKIP_EN
  logic [SKIP_LOG2-1:0] frame_cnt_q;
  assign frame_sel = (frame_cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_cnt_q <= '0;
    end else if ((state_q == WAIT) && fv_rise) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end
`else
  assign frame_sel = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      eof_pend_q <= 1'b0;
      stat_q     <= '0;
    end else begin
      sof_q      <= 1'b0;
      eof_q      <= eof_pend_q;
      eof_pend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fv_q) state_q <= WAIT;
        end
        WAIT: begin
          if (fv_rise) begin
            if (ENABLE && frame_sel) begin
              state_q <= ACTIVE;
              sof_q   <= 1'b1;
              stat_q  <= '0;
              x_q     <= '0;
              y_q     <= '0;
            end else begin
              state_q <= DROP;
            end
          end
        end
        ACTIVE: begin
          if (lv_act && (x_q != H_MAX)) x_q <= x_q + 1'b1;
          if (line_end) begin
            x_q <= '0;
            y_q <= y_next;
            if (x_q < H_MAX) stat_q[STAT_SHORT_LINE] <= 1'b1;
          end
          if (fv_fall) begin
            state_q <= WAIT;
            // A held pixel is flushed this cycle, so the end pulse waits one more.
            if (pend) eof_pend_q <= 1'b1;
            else      eof_q      <= 1'b1;
            if (y_next < V_MAX) stat_q[STAT_SHORT_FRAME] <= 1'b1;
          end
        end
        DROP: begin
          if (fv_fall) state_q <= WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pixel_packer u_packer (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .pix_i    (data_q),
    .accept_i (accept),
    .flush_i  (flush),
    .clear_i  (clear),
    .data_o   (oDATA),
    .wr_o     (oWR),
    .pend_o   (pend)
  );

  assign oSOF  = sof_q;
  assign oEOF  = eof_q;
  assign oSTAT = stat_q;

endmodule

// File: tb/tb_lupa_frame_gate.sv
// Directed testbench for lupa_frame_gate with a small 16x4 window.
module tb_lupa_frame_gate;

  localparam int H = 16;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        RESET, ENABLE, iLV, iFV;
  logic [7:0]  iDATA;
  logic [15:0] oDATA;
  logic        oWR, oSOF, oEOF;
  logic [1:0]  oSTAT;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lupa_frame_gate #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_LOG2(2)) dut (
    .CLK    (clk),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .iDATA  (iDATA),
    .iLV    (iLV),
    .iFV    (iFV),
    .oDATA  (oDATA),
    .oWR    (oWR),
    .oSOF   (oSOF),
    .oEOF   (oEOF),
    .oSTAT  (oSTAT)
  );

  // Output capture on the falling edge.
  logic [15:0] words[$];
  int   sof_cnt = 0, eof_cnt = 0, b2b_cnt = 0, eofwr_cnt = 0;
  logic wr_prev = 1'b0;

  always @(negedge clk) begin
    if (oWR === 1'b1) begin
      words.push_back(oDATA);
      if (wr_prev === 1'b1) b2b_cnt++;
    end
    if (oSOF === 1'b1) sof_cnt++;
    if (oEOF === 1'b1) begin
      eof_cnt++;
      if (oWR === 1'b1) eofwr_cnt++;
    end
    wr_prev = oWR;
  end

  task automatic step(input logic fv, input logic lv, input logic [7:0] d);
    iFV = fv; iLV = lv; iDATA = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    RESET = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_open();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic frame_close();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_line(input int n, input logic [7:0] base);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      step(1'b1, 1'b1, d);
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    total++; if (oDATA !== 16'h0000) begin bad++; $display("FAIL reset_oDATA got=%h exp=0000", oDATA); end
    total++; if (oWR   !== 1'b0)     begin bad++; $display("FAIL reset_oWR got=%b exp=0", oWR); end
    total++; if (oSOF  !== 1'b0)     begin bad++; $display("FAIL reset_oSOF got=%b exp=0", oSOF); end
    total++; if (oEOF  !== 1'b0)     begin bad++; $display("FAIL reset_oEOF got=%b exp=0", oEOF); end
    total++; if (oSTAT !== 2'b00)    begin bad++; $display("FAIL reset_oSTAT got=%b exp=00", oSTAT); end
    RESET = 1'b0;
  endtask

  task automatic test_timing();
    do_reset();
    step(1'b1, 1'b0, 8'h00);
    total++; if (oSOF !== 1'b0) begin bad++; $display("FAIL sof_early got=%b exp=0", oSOF); end
    step(1'b1, 1'b0, 8'h00);
    total++; if (oSOF !== 1'b1) begin bad++; $display("FAIL sof_latency got=%b exp=1", oSOF); end
    step(1'b1, 1'b1, 8'hA5);
    total++; if (oSOF !== 1'b0) begin bad++; $display("FAIL sof_width got=%b exp=0", oSOF); end
    step(1'b1, 1'b1, 8'h5A);
    total++; if (oWR !== 1'b0) begin bad++; $display("FAIL wr_early got=%b exp=0", oWR); end
    step(1'b1, 1'b0, 8'h00);
    total++; if (oWR !== 1'b1 || oDATA !== 16'hA55A) begin
      bad++; $display("FAIL word_latency got=%b/%h exp=1/a55a", oWR, oDATA);
    end
    step(1'b1, 1'b0, 8'h00);
    total++; if (oWR !== 1'b0) begin bad++; $display("FAIL no_flush_even got=%b exp=0", oWR); end
    frame_close();
    total++; if (oSTAT !== 2'b11) begin bad++; $display("FAIL short_line_frame_stat got=%b exp=11", oSTAT); end
  endtask

  task automatic test_full_frame();
    int w0, s0, e0;
    logic [7:0] hi, lo;
    logic [15:0] exp;
    do_reset();
    w0 = words.size(); s0 = sof_cnt; e0 = eof_cnt;
    frame_open();
    for (int l = 0; l < V; l++) run_line(H, 8'(l * H));
    frame_close();
    total++; if (words.size() - w0 != 32) begin bad++; $display("FAIL full_words got=%0d exp=32", words.size() - w0); end
    total++; if (sof_cnt - s0 != 1) begin bad++; $display("FAIL full_sof got=%0d exp=1", sof_cnt - s0); end
    total++; if (eof_cnt - e0 != 1) begin bad++; $display("FAIL full_eof got=%0d exp=1", eof_cnt - e0); end
    total++; if (oSTAT !== 2'b00) begin bad++; $display("FAIL full_stat got=%b exp=00", oSTAT); end
    if (words.size() - w0 >= 32) begin
      for (int k = 0; k < 32; k++) begin
        hi = 8'(2 * k); lo = 8'(2 * k + 1); exp = {hi, lo};
        total++; if (words[w0 + k] !== exp) begin
          bad++; $display("FAIL full_word%0d got=%h exp=%h", k, words[w0 + k], exp);
        end
      end
    end
  endtask

  task automatic test_crop();
    int w0;
    do_reset();
    w0 = words.size();
    frame_open();
    run_line(H + 1, 8'h00);
    run_line(5, 8'h20);
    run_line(H, 8'h40);
    run_line(H, 8'h60);
    run_line(H, 8'h80);
    frame_close();
    total++; if (words.size() - w0 != 27) begin bad++; $display("FAIL crop_words got=%0d exp=27", words.size() - w0); end
    if (words.size() - w0 >= 27) begin
      total++; if (words[w0 + 7]  !== 16'h0E0F) begin bad++; $display("FAIL long_last got=%h exp=0e0f", words[w0 + 7]); end
      total++; if (words[w0 + 8]  !== 16'h2021) begin bad++; $display("FAIL short_w0 got=%h exp=2021", words[w0 + 8]); end
      total++; if (words[w0 + 9]  !== 16'h2223) begin bad++; $display("FAIL short_w1 got=%h exp=2223", words[w0 + 9]); end
      total++; if (words[w0 + 10] !== 16'h2400) begin bad++; $display("FAIL short_flush got=%h exp=2400", words[w0 + 10]); end
      total++; if (words[w0 + 26] !== 16'h6E6F) begin bad++; $display("FAIL crop_last got=%h exp=6e6f", words[w0 + 26]); end
    end
    total++; if (oSTAT !== 2'b01) begin bad++; $display("FAIL crop_stat got=%b exp=01", oSTAT); end
  endtask

  task automatic test_skip();
    int s0, w0, exp_sof;
`ifdef FRAME_SKIP_EN
    exp_sof = 2;
`else
    exp_sof = 8;
`endif
    do_reset();
    s0 = sof_cnt; w0 = words.size();
    for (int f = 0; f < 8; f++) begin
      frame_open();
      run_line(2, 8'(f));
      frame_close();
    end
    total++; if (sof_cnt - s0 != exp_sof) begin bad++; $display("FAIL skip_sof got=%0d exp=%0d", sof_cnt - s0, exp_sof); end
    total++; if (words.size() - w0 != exp_sof) begin bad++; $display("FAIL skip_words got=%0d exp=%0d", words.size() - w0, exp_sof); end
  endtask

  task automatic test_enable();
    int s0, e0, w0;
    do_reset();
    ENABLE = 1'b1;
    s0 = sof_cnt; e0 = eof_cnt; w0 = words.size();
    frame_open();
    run_line(4, 8'h10);
    ENABLE = 1'b0;
    run_line(4, 8'h20);
    frame_close();
    total++; if (sof_cnt - s0 != 1) begin bad++; $display("FAIL en_drop_sof got=%0d exp=1", sof_cnt - s0); end
    total++; if (eof_cnt - e0 != 1) begin bad++; $display("FAIL en_drop_eof got=%0d exp=1", eof_cnt - e0); end
    total++; if (words.size() - w0 != 4) begin bad++; $display("FAIL en_drop_words got=%0d exp=4", words.size() - w0); end
    s0 = sof_cnt; e0 = eof_cnt; w0 = words.size();
    frame_open();
    ENABLE = 1'b1;
    run_line(4, 8'h30);
    frame_close();
    total++; if (sof_cnt - s0 != 0) begin bad++; $display("FAIL dropped_sof got=%0d exp=0", sof_cnt - s0); end
    total++; if (eof_cnt - e0 != 0) begin bad++; $display("FAIL dropped_eof got=%0d exp=0", eof_cnt - e0); end
    total++; if (words.size() - w0 != 0) begin bad++; $display("FAIL dropped_words got=%0d exp=0", words.size() - w0); end
  endtask

  task automatic test_eof_flush();
    do_reset();
    frame_open();
    step(1'b1, 1'b1, 8'hC1);
    step(1'b1, 1'b1, 8'hC2);
    step(1'b1, 1'b1, 8'hC3);
    total++; if (oWR !== 1'b1 || oDATA !== 16'hC1C2) begin
      bad++; $display("FAIL eof_pair got=%b/%h exp=1/c1c2", oWR, oDATA);
    end
    step(1'b0, 1'b0, 8'h00);
    total++; if (oWR !== 1'b0) begin bad++; $display("FAIL eof_gap got=%b exp=0", oWR); end
    step(1'b0, 1'b0, 8'h00);
    total++; if (oWR !== 1'b1 || oDATA !== 16'hC300 || oEOF !== 1'b0) begin
      bad++; $display("FAIL eof_flush got=%b/%h/%b exp=1/c300/0", oWR, oDATA, oEOF);
    end
    step(1'b0, 1'b0, 8'h00);
    total++; if (oEOF !== 1'b1 || oWR !== 1'b0) begin
      bad++; $display("FAIL eof_after_flush got=%b/%b exp=1/0", oEOF, oWR);
    end
    step(1'b0, 1'b0, 8'h00);
    total++; if (oSTAT !== 2'b11) begin bad++; $display("FAIL eof_stat got=%b exp=11", oSTAT); end
  endtask

  task automatic test_reset_mid();
    int w0, s0;
    do_reset();
    frame_open();
    run_line(4, 8'h10);
    step(1'b1, 1'b1, 8'h30);
    step(1'b1, 1'b1, 8'h31);
    RESET = 1'b1;
    step(1'b1, 1'b1, 8'h32);
    total++; if (oWR !== 1'b0 || oDATA !== 16'h0000) begin
      bad++; $display("FAIL midreset_wr got=%b/%h exp=0/0000", oWR, oDATA);
    end
    total++; if (oSTAT !== 2'b00 || oSOF !== 1'b0 || oEOF !== 1'b0) begin
      bad++; $display("FAIL midreset_ctl got=%b/%b/%b exp=00/0/0", oSTAT, oSOF, oEOF);
    end
    RESET = 1'b0;
    w0 = words.size(); s0 = sof_cnt;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(8'h40 + i));
    run_line(4, 8'h50);
    total++; if (words.size() - w0 != 0) begin bad++; $display("FAIL midreset_nowr got=%0d exp=0", words.size() - w0); end
    frame_close();
    frame_open();
    run_line(2, 8'h77);
    frame_close();
    total++; if (words.size() - w0 != 1) begin bad++; $display("FAIL resync_words got=%0d exp=1", words.size() - w0); end
    total++; if (sof_cnt - s0 != 1) begin bad++; $display("FAIL resync_sof got=%0d exp=1", sof_cnt - s0); end
    if (words.size() > 0) begin
      total++; if (words[words.size() - 1] !== 16'h7778) begin
        bad++; $display("FAIL resync_word got=%h exp=7778", words[words.size() - 1]);
      end
    end
  endtask

  task automatic test_protocol();
    total++; if (b2b_cnt != 0) begin bad++; $display("FAIL wr_back_to_back got=%0d exp=0", b2b_cnt); end
    total++; if (eofwr_cnt != 0) begin bad++; $display("FAIL eof_with_wr got=%0d exp=0", eofwr_cnt); end
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; iLV = 1'b0; iFV = 1'b0; iDATA = 8'h00;
    test_reset();
    test_timing();
    test_full_frame();
    test_crop();
    test_skip();
    test_enable();
    test_eof_flush();
    test_reset_mid();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lupa_frame_gate.md
# lupa_frame_gate

Capture-side stage between the LUPA300 sensor reader and the SDRAM controller write port. It takes 8-bit mono pixels with line/frame valid, crops to the active window, and optionally keeps only every 2^SKIP_LOG2-th frame. It packs pixel pairs into 16-bit words with a one-cycle write strobe and emits frame start/end pulses for the SDRAM write-side FIFO and address reset.

## Interface
- H_ACTIVE, 640, pixels kept per line
- V_ACTIVE, 480, lines kept per frame
- SKIP_LOG2, 2, frame decimation: keep 1 of 2^SKIP_LOG2 frames (used only with FRAME_SKIP_EN)
- CLK  in  1  pixel clock (clk_80Mb domain)
- RESET  in  1  reset, synchronous and active-high
- ENABLE  in  1  capture enable, sampled only at frame start
- iDATA  in  8  pixel from sensor reader
- iLV  in  1  line valid
- iFV  in  1  frame valid
- oDATA  out  16  packed word {first pixel, second pixel}
- oWR  out  1  one-cycle strobe, oDATA valid
- oSOF  out  1  one-cycle pulse, accepted frame begins
- oEOF  out  1  one-cycle pulse, accepted frame ended
- oSTAT  out  2  bit0 short line seen, bit1 short frame; sticky, cleared on oSOF

## Operation
- iDATA/iLV/iFV registered once on entry; all logic uses registered copies; edges detected against previous registered value.
- States: IDLE, WAIT, ACTIVE, DROP. RESET -> IDLE.
- IDLE: FV low -> WAIT (resynchronises after reset mid-frame; partial frame discarded).
- WAIT: FV rising: if ENABLE and frame selected -> ACTIVE, pulse oSOF, clear oSTAT, zero x/y counters; else -> DROP.
- ACTIVE: pixel accepted when LV high, x < H_ACTIVE, y < V_ACTIVE; x increments per LV-high pixel (saturates at H_ACTIVE). LV falling: flush, if x < H_ACTIVE set oSTAT[0]; y increments (saturates at V_ACTIVE); x cleared. FV falling -> WAIT, pulse oEOF; y < V_ACTIVE sets oSTAT[1].
- DROP: no writes; FV falling -> WAIT.
- Packing: even accepted pixel held in high byte; odd pixel completes word, oWR=1. Flush at line end with odd count: word {held, 8'h00} written.
- FV falls while LV high: treated as line end then frame end; flush word precedes oEOF.
- ENABLE change mid-frame ignored until next FV rise.
- Reset values: oDATA=0, oWR=0, oSOF=0, oEOF=0, oSTAT=0, frame counter=0.

## Timing
- Pixel on iDATA at edge N is registered at N; completing word appears on oDATA/oWR after edge N+1 (latency 2 edges from pin to strobe).
- oSOF high for the cycle after registered FV rise (2 edges after iFV rises).
- Flush word: oWR the cycle after registered LV fall; oEOF the cycle after the final flush/word, never same cycle as oWR.
- Max write rate 1 word per 2 cycles; oWR never high two consecutive cycles except flush immediately following a completed word is impossible (flush only on odd count).

## Configuration
- FRAME_SKIP_EN defined: SKIP_LOG2-bit frame counter increments on every FV rise seen in WAIT (wraps); frame selected when counter == 0 before increment. First frame after reset is kept.
- Undefined: counter absent; every frame with ENABLE high is accepted; SKIP_LOG2 ignored.

## Structure
- Package lupa_cap_pkg: state enum (IDLE, WAIT, ACTIVE, DROP), default H_ACTIVE/V_ACTIVE constants, oSTAT bit indices.
- Sub-module pixel_packer: byte-pair accumulator with accept/flush/clear inputs, produces oDATA/oWR; top holds FSM, counters, edge detect.

## Test plan
- 640x480 frame, pixels incrementing mod 256, ENABLE=1 -> 153600 oWR words, first word 16'h0001, oSOF once, oEOF once, oSTAT=0.
- Line of 641 pixels -> 320 words, last word {8'h7E,8'h7F}-pattern per line, pixel 641 dropped; line of 5 pixels -> 3 words, third {p4,8'h00}, oSTAT[0]=1.
- FRAME_SKIP_EN, SKIP_LOG2=2, 8 frames -> oSOF on frames 0 and 4 only; without macro -> 8 oSOF.
- RESET asserted mid-line -> outputs 0 next cycle; no writes until FV low then new FV rise.
- ENABLE drops mid-frame -> frame completes with oEOF; next frame goes DROP, no oWR; FV falling with LV high and odd count -> flush word then oEOF next cycle.
